// File: rtl/user_fpga_format_if.sv
// Memory request/read port plus host start/done handshake and best-score results.
// Memory is combinational and never stalls the engine; the host sequences starts via ready_2_start.
interface user_fpga_format_if;
    logic        req;
    logic        rd_wr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        set_done;
    logic [6:0]  row;
    logic [6:0]  col;
    logic        tem_win;
    logic        ready_2_start;
    logic [63:0] greatestNCCLog2;
    logic [8:0]  greatestWindowIndex;

    modport master (
        output req, rd_wr, write_data, set_done, row, col, tem_win,
               greatestNCCLog2, greatestWindowIndex,
        input  read_data, ready_2_start
    );

    modport slave (
        input  req, rd_wr, write_data, set_done, row, col, tem_win,
               greatestNCCLog2, greatestWindowIndex,
        output read_data, ready_2_start
    );
endinterface

// File: rtl/user_fpga_format.sv
// Template matcher: Mitchell-log2 NCC score per window, best window written back, then set_done.
// One pixel per cycle plus one score cycle per window; no backpressure (memory answers same cycle).
module user_fpga_format #(
    parameter int TEMP_SIZE    = 4,
    parameter int WIN_PER_SIDE = 16,
    parameter int STEP         = 4
) (
    input logic                clk,
    input logic                rst_n,
    user_fpga_format_if.master bus
);
    localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;
    localparam logic [6:0]  LAST_PIX = 7'(TEMP_SIZE - 1);
    localparam logic [6:0]  STEP_A   = 7'(STEP);
    localparam logic [8:0]  LAST_WC  = 9'(WIN_PER_SIDE - 1);
    localparam logic [8:0]  LAST_WIN = 9'(WIN_PER_SIDE * WIN_PER_SIDE - 1);

    typedef enum logic [2:0] {IDLE, LOAD_T, READ_W, SCORE, WRITE, DONE} state_t;

    function automatic logic [63:0] mlog2(input logic [31:0] x);
        logic [63:0] r;
        logic [31:0] f;
        r = '0;
        f = '0;
        for (int b = 0; b < 32; b++) begin
            if (x[b]) begin
                r[63:54] = 10'(b);
                f        = x << (32 - b);
            end
        end
        r[53:22] = f;
        return r;
    endfunction

    state_t      state;
    logic        req, rd_wr, set_done, tem_win;
    logic [31:0] write_data;
    logic [6:0]  row, col;
    logic [63:0] best;
    logic [8:0]  best_idx;
    logic [6:0]  pi, pj, base_row, base_col;
    logic [5:0]  tidx;
    logic [8:0]  k, wc;
    logic [31:0] st, stw, sw;
    logic [7:0]  tmpl [64];

    logic [7:0]  pix;
    logic        unused_rd;
    logic        last_pix;
    logic [6:0]  pi_nx, pj_nx;
    logic [15:0] sq_w, prod_tw;
    logic [63:0] score;
    logic        better;

    assign pix       = bus.read_data[7:0];
    assign unused_rd = ^bus.read_data[31:8];
    assign last_pix  = (pi == LAST_PIX) && (pj == LAST_PIX);
    assign pj_nx     = (pj == LAST_PIX) ? 7'd0 : pj + 7'd1;
    assign pi_nx     = (pj == LAST_PIX) ? pi + 7'd1 : pi;
    assign sq_w      = {8'd0, pix} * {8'd0, pix};
    assign prod_tw   = {8'd0, tmpl[tidx]} * {8'd0, pix};

    // A zero sum has no log; such a window can never win.
    assign score  = (mlog2(stw) << 1) - mlog2(st) - mlog2(sw);
    assign better = (stw != 32'd0) && (st != 32'd0) && (sw != 32'd0) &&
                    ($signed(score) > $signed(best));

    assign bus.req                 = req;
    assign bus.rd_wr               = rd_wr;
    assign bus.write_data          = write_data;
    assign bus.set_done            = set_done;
    assign bus.row                 = row;
    assign bus.col                 = col;
    assign bus.tem_win             = tem_win;
    assign bus.greatestNCCLog2     = best;
    assign bus.greatestWindowIndex = best_idx;

    always_ff @(posedge clk) begin
        if (state == LOAD_T) tmpl[tidx] <= pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            req <= 1'b0; rd_wr <= 1'b0; write_data <= '0; set_done <= 1'b0;
            row <= '0; col <= '0; tem_win <= 1'b0;
            best <= MOST_NEG; best_idx <= '0;
            pi <= '0; pj <= '0; tidx <= '0; base_row <= '0; base_col <= '0;
            k <= '0; wc <= '0; st <= '0; stw <= '0; sw <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ready_2_start) begin
                        best <= MOST_NEG; best_idx <= '0;
                        st <= '0; stw <= '0; sw <= '0;
                        pi <= '0; pj <= '0; tidx <= '0;
                        req <= 1'b1; rd_wr <= 1'b1; tem_win <= 1'b1;
                        row <= '0; col <= '0;
                        state <= LOAD_T;
                    end
                end
                LOAD_T: begin
                    st <= st + {16'd0, sq_w};
                    if (last_pix) begin
                        pi <= '0; pj <= '0; tidx <= '0;
                        base_row <= '0; base_col <= '0; k <= '0; wc <= '0;
                        tem_win <= 1'b0; row <= '0; col <= '0;
                        state <= READ_W;
                    end else begin
                        pi <= pi_nx; pj <= pj_nx; tidx <= tidx + 6'd1;
                        row <= pi_nx; col <= pj_nx;
                    end
                end
                READ_W: begin
                    stw <= stw + {16'd0, prod_tw};
                    sw  <= sw + {16'd0, sq_w};
                    if (last_pix) begin
                        pi <= '0; pj <= '0; tidx <= '0;
                        req <= 1'b0; rd_wr <= 1'b0;
                        state <= SCORE;
                    end else begin
                        pi <= pi_nx; pj <= pj_nx; tidx <= tidx + 6'd1;
                        row <= base_row + pi_nx; col <= base_col + pj_nx;
                    end
                end
                SCORE: begin
                    if (better) begin
                        best <= score; best_idx <= k;
                    end
                    stw <= '0; sw <= '0;
                    if (k == LAST_WIN) begin
                        req <= 1'b1; rd_wr <= 1'b0; tem_win <= 1'b0;
                        row <= '0; col <= '0;
                        write_data <= {23'd0, better ? k : best_idx};
                        state <= WRITE;
                    end else begin
                        k <= k + 9'd1;
                        req <= 1'b1; rd_wr <= 1'b1;
                        if (wc == LAST_WC) begin
                            wc <= '0; base_col <= '0; base_row <= base_row + STEP_A;
                            row <= base_row + STEP_A; col <= '0;
                        end else begin
                            wc <= wc + 9'd1; base_col <= base_col + STEP_A;
                            row <= base_row; col <= base_col + STEP_A;
                        end
                        state <= READ_W;
                    end
                end
                WRITE: begin
                    req <= 1'b0; rd_wr <= 1'b0; write_data <= '0;
                    set_done <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (!bus.ready_2_start) begin
                        set_done <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_user_fpga_format.sv
// Bench for user_fpga_format: combinational memory, directed and random images, NCC reference model.
module tb_user_fpga_format;
    localparam int N       = 4;
    localparam int W       = 16;
    localparam int STEP    = 4;
    localparam int NPIX    = N * N;
    localparam int RUN_CYC = 1 + NPIX + W * W * (NPIX + 1) + 1;
    localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    user_fpga_format_if bus();

    user_fpga_format #(.TEMP_SIZE(N), .WIN_PER_SIDE(W), .STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] tmem [128][128];
    logic [7:0] img  [128][128];

    // Upper read_data bits carry junk the engine must ignore.
    always_comb begin
        bus.read_data = {bus.row, bus.col, 10'h2a5,
                         bus.tem_win ? tmem[bus.row][bus.col] : img[bus.row][bus.col]};
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic longint ref_log2(input longint x);
        int p = 0;
        while ((longint'(1) << (p + 1)) <= x) p++;
        return (longint'(p) << 54) + ((x - (longint'(1) << p)) << (54 - p));
    endfunction

    task automatic ref_model(output logic [63:0] eb, output logic [8:0] ei);
        longint st, stw, sw, s, best, t, w;
        int idx;
        st = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                t  = longint'(tmem[i][j]);
                st += t * t;
            end
        best = $signed(MOST_NEG);
        idx  = 0;
        for (int kw = 0; kw < W * W; kw++) begin
            stw = 0;
            sw  = 0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    t = longint'(tmem[i][j]);
                    w = longint'(img[(kw / W) * STEP + i][(kw % W) * STEP + j]);
                    stw += t * w;
                    sw  += w * w;
                end
            if (st != 0 && stw != 0 && sw != 0) begin
                s = 2 * ref_log2(stw) - ref_log2(st) - ref_log2(sw);
                if (s > best) begin
                    best = s;
                    idx  = kw;
                end
            end
        end
        eb = best;
        ei = 9'(idx);
    endtask

    // Expected bus activity in cycle c after the start is sampled.
    function automatic bit trace_ok(input int c, input logic [8:0] widx);
        int q, kw, p;
        if (c <= NPIX)
            return bus.req === 1'b1 && bus.rd_wr === 1'b1 && bus.tem_win === 1'b1 &&
                   bus.row === 7'((c - 1) / N) && bus.col === 7'((c - 1) % N) &&
                   bus.write_data === 32'd0;
        if (c == RUN_CYC - 1)
            return bus.req === 1'b1 && bus.rd_wr === 1'b0 && bus.tem_win === 1'b0 &&
                   bus.row === 7'd0 && bus.col === 7'd0 && bus.write_data === {23'd0, widx};
        if (c >= RUN_CYC) return 1'b0;
        q  = c - NPIX - 1;
        kw = q / (NPIX + 1);
        p  = q % (NPIX + 1);
        if (p == NPIX) return bus.req === 1'b0 && bus.write_data === 32'd0;
        return bus.req === 1'b1 && bus.rd_wr === 1'b1 && bus.tem_win === 1'b0 &&
               bus.row === 7'((kw / W) * STEP + p / N) &&
               bus.col === 7'((kw % W) * STEP + p % N) && bus.write_data === 32'd0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, 64'({bus.req, bus.rd_wr, bus.set_done, bus.tem_win}), 64'd0);
        check({tag, "_addr"}, 64'({bus.row, bus.col}), 64'd0);
        check({tag, "_wdata"}, 64'(bus.write_data), 64'd0);
        check({tag, "_best"}, bus.greatestNCCLog2, MOST_NEG);
        check({tag, "_index"}, 64'(bus.greatestWindowIndex), 64'd0);
    endtask

    task automatic do_run(input string tag);
        logic [63:0] eb, best_at_start;
        logic [8:0]  ei;
        logic [31:0] wd_seen;
        int done_cyc, bad;
        ref_model(eb, ei);
        @(negedge clk);
        bus.ready_2_start = 1'b1;
        done_cyc      = 0;
        bad           = 0;
        wd_seen       = 32'hffff_ffff;
        best_at_start = '0;
        for (int c = 1; c <= RUN_CYC + 20 && done_cyc == 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) best_at_start = bus.greatestNCCLog2;
            if (bus.req === 1'b1 && bus.rd_wr === 1'b0) wd_seen = bus.write_data;
            if (bus.set_done === 1'b1) done_cyc = c;
            else if (!trace_ok(c, ei)) bad++;
        end
        check({tag, "_best_cleared"}, best_at_start, MOST_NEG);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(RUN_CYC));
        check({tag, "_trace_errs"}, 64'(bad), 64'd0);
        check({tag, "_write_data"}, 64'(wd_seen), 64'(ei));
        check({tag, "_best"}, bus.greatestNCCLog2, eb);
        check({tag, "_index"}, 64'(bus.greatestWindowIndex), 64'(ei));
    endtask

    task automatic end_run(input string tag);
        @(negedge clk);
        bus.ready_2_start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_cleared"}, 64'(bus.set_done), 64'd0);
    endtask

    task automatic fill_const(input logic [7:0] tv, input logic [7:0] iv);
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++) begin
                tmem[i][j] = tv;
                img[i][j]  = iv;
            end
    endtask

    initial begin
        int hold_bad;
        bus.ready_2_start = 1'b0;
        fill_const(8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        fill_const(8'd16, 8'd16);
        do_run("all16");
        end_run("all16");

        fill_const(8'd0, 8'd0);
        do_run("all0");
        end_run("all0");

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                tmem[i][j]          = 8'(i * N + j + 1);
                img[8 + i][20 + j]  = 8'(i * N + j + 1);
            end
        do_run("patch37");
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.req !== 1'b0 || bus.set_done !== 1'b1) hold_bad++;
        end
        check("hold_done", 64'(hold_bad), 64'd0);
        end_run("patch37");

        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++) begin
                tmem[i][j] = 8'($urandom);
                img[i][j]  = 8'($urandom);
            end
        do_run("rand_full");
        end_run("rand_full");

        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++) begin
                tmem[i][j] = 8'($urandom_range(1, 255));
                img[i][j]  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'd0;
            end
        do_run("rand_sparse");
        end_run("rand_sparse");

        @(negedge clk);
        bus.ready_2_start = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.ready_2_start = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++) img[i][j] = 8'($urandom_range(0, 63));
        do_run("restart");
        end_run("restart");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/user_fpga_format.md
Name: user_fpga_format

Overview:
- Template-matching engine for the astro image pipeline.
- Reads an N×N template from template memory, then reads a grid of candidate windows from image memory, all through a single request/read port.
- Scores each window with a base-2-log approximation of squared normalized cross-correlation and reports the best window's score and index.
- Writes the winning index back to memory, then raises set_done to the host sequencer, which drives ready_2_start.

Parameters:
- TEMP_SIZE, 4, template/window edge N in pixels (N² ≤ 64).
- WIN_PER_SIDE, 16, windows per grid row and per grid column; WIN_PER_SIDE² ≤ 512.
- STEP, 4, pixel stride between window origins; (WIN_PER_SIDE-1)·STEP + TEMP_SIZE ≤ 128.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  out  1  memory access strobe.
- rd_wr  out  1  1 = read, 0 = write; meaningful only while req=1.
- write_data  out  32  write payload.
- read_data  in  32  memory read data; pixel is bits [7:0], upper bits ignored.
- set_done  out  1  run complete.
- row  out  7  memory row address.
- col  out  7  memory column address.
- tem_win  out  1  1 = template memory, 0 = image memory.
- ready_2_start  in  1  host start / level handshake.
- greatestNCCLog2  out  64  signed fixed point Q10.54 (bits [9:-54]), best score.
- greatestWindowIndex  out  9  index of best window.

Behaviour:
- Memory model: combinational. read_data for the row/col/tem_win driven in a req=1, rd_wr=1 cycle is sampled at the rising edge ending that cycle.

Reset:
- req=0, rd_wr=0, write_data=0, set_done=0, row=0, col=0, tem_win=0.
- greatestNCCLog2=64'h8000_0000_0000_0000 (most negative), greatestWindowIndex=0.
- State IDLE.

FSM:
- IDLE: all strobes low. When ready_2_start=1, clear best to most negative and index to 0, then go to LOAD_T.
- LOAD_T: N² cycles with req=1, rd_wr=1, tem_win=1, row-major addressing (col fastest), row/col = 0..N-1. Store pixels and accumulate St = Σt².
- READ_W: for window k = wr·WIN_PER_SIDE + wc (wr, wc = 0..WIN_PER_SIDE-1, k ascending), run N² cycles with req=1, rd_wr=1, tem_win=0.
  - Address row = wr·STEP + i, col = wc·STEP + j, row-major.
  - Accumulate Stw = Σt·w and Sw = Σw² in 32-bit unsigned accumulators.
- SCORE: 1 cycle, req=0.
  - Compute s = 2·L(Stw) − L(St) − L(Sw).
  - If s > best (signed, strict), update best to s and index to k. Ties keep the earlier window.
  - Clear the window accumulators. Go to the next window, or to WRITE after the last window.
- WRITE: 1 cycle with req=1, rd_wr=0, tem_win=0, row=0, col=0, write_data = {23'b0, greatestWindowIndex}.
- DONE: set_done=1 and best outputs held, until ready_2_start=0, then IDLE. best outputs persist until the next start.
- req=0 and write_data=0 in every state not listed above.

L(x), Mitchell log2 of a 32-bit unsigned value:
- Integer part = position p of the leading one.
- Fraction = the bits below the leading one, left-justified into 54 bits, zero-filled.
- Result is Q10.54, non-negative.
- If any of Stw, St, Sw is 0, s = most negative and no update occurs.

Arithmetic and timing:
- All score arithmetic is 64-bit signed two's complement; no overflow is possible.
- Cycle count from start to set_done = 1 (IDLE) + N² + WIN_PER_SIDE²·(N²+1) + 1 (WRITE). Defaults give 4370.
- ready_2_start dropping mid-run is ignored; the run completes.
- Reset mid-run aborts immediately to the reset values.

Test Plan:
- Template memory and image memory all read 16 -> sums are all 4096 = 2^12, so every s=0; greatestNCCLog2=0, greatestWindowIndex=0; write cycle carries write_data=0; set_done rises 4370 cycles after start.
- All memory reads 0 -> greatestNCCLog2=64'h8000_0000_0000_0000, index 0, set_done asserts.
- Template = distinct nonzero 4×4 pattern; image zero except the identical patch at origin (8,20) -> index 2·16+5=37, greatestNCCLog2=0, write_data=37.
- Address trace -> first 16 requests tem_win=1 at (0,0)..(3,3) row-major; window 1 reads rows 0..3, cols 4..7; 17th cycle of each window has req=0.
- Hold ready_2_start=1 after done -> set_done stays 1, no new requests; drop it -> IDLE; reassert -> a new run starts and best is reset first.
- Assert rst_n=0 mid READ_W -> all outputs return to reset values; the next start restarts at the template load.
